// File: rtl/router_out_fifo.sv
// Per-destination output FIFO of the 1x3 router: stores header-tagged bytes,
// tracks packet boundaries on the read side and soft-resets on reader timeout.
module router_out_fifo #(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_enb,
  input  logic             lfd,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             full,
  output logic             empty,
  output logic             pkt_done,
  output logic             soft_rst
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [WIDTH:0]   r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [6:0]       r_pkt_cnt;
  logic [TW-1:0]    r_tmo_cnt;
  logic [WIDTH-1:0] r_data_out;
  logic             r_pkt_done;
  logic             r_soft_rst;

  logic             w_empty;
  logic             w_full;
  logic             w_tmo_fire;
  logic             w_do_wr;
  logic             w_do_rd;
  logic [WIDTH:0]   w_rd_entry;
  logic [6:0]       w_hdr_cnt;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // The soft reset wins over any write arriving in the same cycle.
  assign w_tmo_fire = !w_empty && !read_enb && (r_tmo_cnt == TW'(TIMEOUT - 1));
  assign w_do_wr    = write_enb && !w_full && !w_tmo_fire;
  assign w_do_rd    = read_enb && !w_empty;
  assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];
  // Header bits [7:2] carry payload length; one more for the parity byte.
  assign w_hdr_cnt  = {1'b0, w_rd_entry[7:2]} + 7'd1;

  assign data_out  = r_data_out;
  assign valid_out = !w_empty;
  assign full      = w_full;
  assign empty     = w_empty;
  assign pkt_done  = r_pkt_done;
  assign soft_rst  = r_soft_rst;

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {lfd, data_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pkt_cnt  <= '0;
      r_tmo_cnt  <= '0;
      r_data_out <= '0;
      r_pkt_done <= 1'b0;
      r_soft_rst <= 1'b0;
    end else if (w_tmo_fire) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pkt_cnt  <= '0;
      r_tmo_cnt  <= '0;
      r_data_out <= '0;
      r_pkt_done <= 1'b0;
      r_soft_rst <= 1'b1;
    end else begin
      r_soft_rst <= 1'b0;
      r_pkt_done <= 1'b0;
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= w_rd_entry[WIDTH-1:0];
        if (w_rd_entry[WIDTH]) begin
          r_pkt_cnt <= w_hdr_cnt;
        end else if (r_pkt_cnt != 7'd0) begin
          r_pkt_cnt  <= r_pkt_cnt - 7'd1;
          r_pkt_done <= (r_pkt_cnt == 7'd1);
        end
      end
      if (read_enb || w_empty) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

endmodule
